nios_sys_input_pio: RTL and testbench
=====================================

# nios_sys_input_pio

Avalon-MM slave input PIO for the Nios system: samples an external `WIDTH`-bit input bus through a synchronizer and exposes the value to the CPU. Detects edges, latches them in a write-1-to-clear capture register, and raises a level interrupt through a per-bit mask. It is the input-direction counterpart of the system's output PIO and sits on the same Avalon data bus, with `irq` routed to the Nios interrupt controller.

## Interface
- `WIDTH`, 4: input port width, 1..32.
- `SYNC_STAGES`, 2: synchronizer depth, 2..4.
- `EDGE_TYPE`, 0: 0 = rising, 1 = falling, 2 = any edge.
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in WIDTH: asynchronous external inputs.
- `readdata` out 32: read data, zero-extended from WIDTH.
- `irq` out 1: level interrupt, active high.

## Operation
- Register map:
  - 0 = DATA, read-only: synchronized input value.
  - 1 = reserved: reads 0, writes ignored.
  - 2 = IRQMASK, read/write.
  - 3 = EDGECAP: reads return captured edges; a write clears each bit whose `writedata` bit is 1.
- A write occurs when `chipselect && !write_n`. Writes to DATA and to reserved address 1 have no effect.
- Reads have no side effects. `readdata` is a combinational mux of the registers, so read latency is 0. Bits 31:WIDTH always read 0.
- Synchronizer: `in_port` passes through `SYNC_STAGES` flops to give `sync`. A further flop holds `prev`.
- Edge term per bit:
  - rising: `sync & ~prev`
  - falling: `~sync & prev`
  - any: `sync ^ prev`
- Arm counter: after reset, edge detection is gated off until `SYNC_STAGES+1` clocks have elapsed. This prevents inputs held static through reset from producing spurious captures. The counter saturates.
- EDGECAP bit update, in priority order:
  - reset → 0
  - armed edge detected → 1
  - clear-write with bit = 1 → 0
  - otherwise hold.
- Set wins over a same-cycle clear.
- `irq = |(EDGECAP & IRQMASK)`, combinational from registers.
- Reset values:
  - all synchronizer flops, `prev`, IRQMASK, EDGECAP and the arm counter are 0
  - `readdata` is therefore 0 while `reset` is high
  - `irq` is 0.
- Reset asserted mid-operation clears everything on that edge; `irq` is low the following cycle.

## Timing
- Let `in_port` change before clock edge N.
  - DATA reflects the change after edge N+SYNC_STAGES−1 (readable in the cycle following).
  - EDGECAP bit sets at edge N+SYNC_STAGES.
  - `irq` rises in that same cycle if the corresponding mask bit is set.
- An IRQMASK write at edge M affects `irq` from the cycle after M.
- An EDGECAP clear at edge M drops `irq` in the cycle after M, unless another set bit remains enabled.
- The arm counter reaches its armed state `SYNC_STAGES+1` edges after the first edge with `reset` low.
- Pulses shorter than one clock period may be missed. This is not required to be detected.

## Structure
- Package `nios_sys_pio_pkg`, containing:
  - register address constants `PIO_ADDR_DATA=0`, `PIO_ADDR_IRQMASK=2`, `PIO_ADDR_EDGECAP=3`
  - edge-type constants `PIO_EDGE_RISE/FALL/ANY`.
- Sub-module `nios_sys_pio_sync`: parameterised WIDTH × SYNC_STAGES flop chain with synchronous active-high reset. Reused by other input-facing blocks.
- The top level holds `prev`, the arm counter, EDGECAP, IRQMASK, the read mux and `irq`.

## Test plan
- **Reset behaviour:** `reset` high 3 cycles with `in_port=4'hF` → `readdata=0` and `irq=0` during reset. After release, DATA reads `0xF` by the 3rd cycle; EDGECAP stays `0x0` (arm gating).
- **Rising edge, masking and clear:** default params, `in_port` 0→`4'h5`, IRQMASK=0 → EDGECAP reads `0x5` 3 cycles later, `irq=0`. Write IRQMASK=`0x4` → `irq=1` the next cycle. Write EDGECAP=`0x4` → EDGECAP reads `0x1`, `irq=0`.
- **Clear/edge collision:** a clear-write of `0x1` on the same edge that bit 0 captures a new rising edge → EDGECAP bit 0 remains 1.
- **Edge types:** `EDGE_TYPE=1`, `in_port` `0xF`→`0xA` → EDGECAP=`0x5`. `EDGE_TYPE=2`, `0x0`→`0x3`→`0x1` → EDGECAP=`0x3`.
- **Ignored accesses:** write `0xFFFFFFFF` to address 0, write to address 1, and a write with `chipselect=0` → no register changes. Address 1 reads 0; bits 31:4 always read 0.
- **Mid-operation reset:** set IRQMASK=`0xF` and EDGECAP=`0xF` so that `irq=1`, then assert reset for 1 cycle → all registers read 0 and `irq=0` the cycle after.

Source files
------------

// File: rtl/nios_sys_pio_pkg.sv
// Shared constants for the Nios system PIO blocks: register map and edge-type selectors.
package nios_sys_pio_pkg;

   // Avalon register addresses (address 1 is reserved)
   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   // Edge polarity selectors for the EDGE_TYPE parameter
   localparam int unsigned PIO_EDGE_RISE = 0;
   localparam int unsigned PIO_EDGE_FALL = 1;
   localparam int unsigned PIO_EDGE_ANY  = 2;

endpackage

// File: rtl/nios_sys_pio_sync.sv
// Multi-stage flop synchronizer for asynchronous input buses.
module nios_sys_pio_sync #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] stage_q;

   // Shift the input through the chain; stage 0 is the metastability-exposed flop
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q <= '0;
      end else begin
         stage_q <= {stage_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/nios_sys_input_pio.sv
// Avalon-MM input PIO: synchronized input, edge capture with W1C clear, masked level IRQ.
module nios_sys_input_pio
   import nios_sys_pio_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_TYPE   = PIO_EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int unsigned ArmCount = SYNC_STAGES + 1;

   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [2:0]       arm_cnt_q, arm_cnt_d;
   logic             armed;
   logic             wr_en;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;

   nios_sys_pio_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (in_port),
      .q_o   (sync)
   );

   assign wr_en = chipselect & ~write_n;
   // Hold off capture until the synchronizer and prev have been refilled after reset
   assign armed = (arm_cnt_q == 3'(ArmCount));

   // Per-bit edge term selected by EDGE_TYPE
   always_comb begin
      edge_det = '0;
      case (EDGE_TYPE)
         PIO_EDGE_FALL: edge_det = ~sync & prev_q;
         PIO_EDGE_ANY:  edge_det = sync ^ prev_q;
         default:       edge_det = sync & ~prev_q;
      endcase
   end

   // Next-state for mask, capture and arm counter; set is applied last so it beats a clear
   always_comb begin
      irq_mask_d = irq_mask_q;
      edge_cap_d = edge_cap_q;
      arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
      if (wr_en && address == PIO_ADDR_IRQMASK) begin
         irq_mask_d = writedata[WIDTH-1:0];
      end
      if (wr_en && address == PIO_ADDR_EDGECAP) begin
         edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
      end
      if (armed) begin
         edge_cap_d = edge_cap_d | edge_det;
      end
   end

   // Register state with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q     <= '0;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         arm_cnt_q  <= '0;
      end else begin
         prev_q     <= sync;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
         arm_cnt_q  <= arm_cnt_d;
      end
   end

   // Zero-latency read mux, upper bits zero-extended
   always_comb begin
      readdata = '0;
      case (address)
         PIO_ADDR_DATA:    readdata[WIDTH-1:0] = sync;
         PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_q;
         PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap_q;
         default:          readdata = '0;
      endcase
   end

   assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_nios_sys_input_pio.sv
// Directed bench for nios_sys_input_pio: three instances (rising, falling, any-edge) on a shared bus.
module tb_nios_sys_input_pio;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port0, in_port1, in_port2;
   logic [31:0] readdata0, readdata1, readdata2;
   logic        irq0, irq1, irq2;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   nios_sys_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_rise (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port0), .readdata(readdata0), .irq(irq0)
   );

   nios_sys_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(1)) u_fall (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port1), .readdata(readdata1), .irq(irq1)
   );

   nios_sys_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(2)) u_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port2), .readdata(readdata2), .irq(irq2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Read one register of the selected instance (0 rise, 1 fall, 2 any) and compare
   task automatic rd(input string tag, input int inst, input logic [1:0] a,
                     input logic [31:0] exp);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      case (inst)
         1:       check(tag, readdata1, exp);
         2:       check(tag, readdata2, exp);
         default: check(tag, readdata0, exp);
      endcase
   endtask

   task automatic wr(input logic cs, input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = cs;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      write_n    = 1'b1;
      chipselect = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port0   = 4'hF;
      in_port1   = 4'hF;
      in_port2   = 4'h0;

      // Reset held three cycles with inputs high
      tick(1);
      rd("rst_data", 0, 2'd0, 32'h0);
      check("rst_irq", {31'd0, irq0}, 32'h0);
      tick(2);
      rd("rst_data_late", 0, 2'd0, 32'h0);
      rd("rst_edgecap", 0, 2'd3, 32'h0);
      check("rst_irq_late", {31'd0, irq0}, 32'h0);

      // Release: DATA fills, arm gating suppresses the static-high input
      reset = 1'b0;
      tick(3);
      rd("arm_data", 0, 2'd0, 32'hF);
      rd("arm_edgecap", 0, 2'd3, 32'h0);
      tick(3);
      rd("arm_edgecap_late", 0, 2'd3, 32'h0);
      rd("arm_edgecap_fall", 1, 2'd3, 32'h0);

      // Rising edge 0 -> 5 with mask 0
      in_port0 = 4'h0;
      tick(4);
      rd("rise_clear_base", 0, 2'd3, 32'h0);
      in_port0 = 4'h5;
      tick(2);
      rd("rise_data_n1", 0, 2'd0, 32'h5);
      rd("rise_cap_n1", 0, 2'd3, 32'h0);
      tick(1);
      rd("rise_cap_n2", 0, 2'd3, 32'h5);
      check("rise_irq_masked", {31'd0, irq0}, 32'h0);

      // Unmask bit 2
      wr(1'b1, 2'd2, 32'h4);
      check("mask_irq", {31'd0, irq0}, 32'h1);
      rd("mask_read", 0, 2'd2, 32'h4);

      // Clear bit 2
      wr(1'b1, 2'd3, 32'h4);
      check("clr_irq", {31'd0, irq0}, 32'h0);
      rd("clr_cap", 0, 2'd3, 32'h1);

      // Clear of bit 0 on the same edge as a new rising edge on bit 0
      in_port0 = 4'h4;
      tick(4);
      rd("coll_pre", 0, 2'd3, 32'h1);
      in_port0 = 4'h5;
      tick(2);
      wr(1'b1, 2'd3, 32'h1);
      rd("coll_set_wins", 0, 2'd3, 32'h1);
      wr(1'b1, 2'd3, 32'h1);
      rd("coll_plain_clear", 0, 2'd3, 32'h0);

      // Falling edges F -> A
      in_port1 = 4'hA;
      tick(3);
      rd("fall_cap", 1, 2'd3, 32'h5);

      // Any edge 0 -> 3 -> 1
      in_port2 = 4'h3;
      tick(3);
      rd("any_cap_a", 2, 2'd3, 32'h3);
      in_port2 = 4'h1;
      tick(3);
      rd("any_cap_b", 2, 2'd3, 32'h3);

      // Ignored accesses
      wr(1'b1, 2'd0, 32'hFFFF_FFFF);
      rd("ign_data", 0, 2'd0, 32'h5);
      rd("ign_mask_a", 0, 2'd2, 32'h4);
      rd("ign_cap_a", 1, 2'd3, 32'h5);
      wr(1'b1, 2'd1, 32'hFFFF_FFFF);
      rd("ign_rsvd", 0, 2'd1, 32'h0);
      rd("ign_mask_b", 0, 2'd2, 32'h4);
      wr(1'b0, 2'd2, 32'h0);
      rd("ign_cs_mask", 0, 2'd2, 32'h4);
      wr(1'b0, 2'd3, 32'hFFFF_FFFF);
      rd("ign_cs_cap", 1, 2'd3, 32'h5);
      wr(1'b1, 2'd2, 32'hFFFF_FFFF);
      rd("mask_zext", 0, 2'd2, 32'hF);

      // Mid-operation reset with irq asserted on the any-edge instance
      in_port2 = 4'hE;
      tick(3);
      rd("mid_cap", 2, 2'd3, 32'hF);
      check("mid_irq_pre", {31'd0, irq2}, 32'h1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("mid_irq_post", {31'd0, irq2}, 32'h0);
      rd("mid_cap_post", 2, 2'd3, 32'h0);
      rd("mid_mask_post", 2, 2'd2, 32'h0);
      rd("mid_data_post", 2, 2'd0, 32'h0);
      tick(4);
      rd("mid_rearm_cap", 2, 2'd3, 32'h0);
      rd("mid_rearm_data", 2, 2'd0, 32'hE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
